// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath.
// Multiply/divide op codes, FSM states and iteration count.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/mul_div_iter.sv
// Shared 64-bit accumulator: one shift-add (mul) or
// restoring shift-subtract (div) step per cycle.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  localparam int W2 = 2 * WIDTH;

  logic             div_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nx;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;
  logic [W2-1:0]    div_nx;

  // mul: acc = {partial, multiplier}, shifted right each step
  assign mul_sum = {1'b0, acc[W2-1:WIDTH]}
                 + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // div: acc = {remainder, dividend/quotient}, shifted left
  assign trial   = acc[W2-1:WIDTH-1];
  assign fits    = trial >= {1'b0, opnd};
  assign rem_sub = acc[W2-2:WIDTH-1] - opnd;
  assign div_nx  = fits
                 ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                 : {acc[W2-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      div_q <= is_div;
      opnd  <= is_div ? b : a;
      acc   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
    end else if (step) begin
      acc <= div_q ? div_nx : mul_nx;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Fixed latency: accept, 32 iterations, one fix-up cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         W2   = 2 * WIDTH;
  localparam logic [5:0] LAST = 6'(MD_ITERS - 1);

  md_state_t        state, state_nx;
  logic [5:0]       cnt;
  logic             div_q, neg_q, rneg_q, dbz_q;
  logic             is_div, is_signed;
  logic             sa, sb, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    acc, prod;
  logic [WIDTH-1:0] quo, rem;

  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign a_mag     = sa ? -a : a;
  assign b_mag     = sb ? -b : b;

  assign busy   = (state != MD_IDLE);
  assign accept = (state == MD_IDLE) && start;

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == MD_CALC),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (acc)
  );

  // Divide-by-zero keeps HI = a for free: |a| remains and is re-signed.
  assign prod = neg_q ? -acc : acc;
  assign quo  = dbz_q ? '1
              : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem  = rneg_q ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MD_IDLE: if (start) state_nx = MD_CALC;
      MD_CALC: if (cnt == LAST) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (1'b1)
        accept: begin
          cnt    <= '0;
          div_q  <= is_div;
          neg_q  <= sa ^ sb;
          rneg_q <= sa;
          dbz_q  <= is_div && (b == '0);
        end
        (state == MD_CALC): cnt <= cnt + 6'd1;
        (state == MD_FIX): begin
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          if (div_q) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Hand-computed HI/LO, latency and boundary vectors.
module tb_mul_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int n, bcnt, dcnt;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for edge 0; operands are scrambled right after.
  task automatic launch(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Bounded wait for done; poke = cycle to inject start+MTHI/MTLO.
  task automatic wait_done(input int poke);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      if (n == poke) begin
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd4;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else if (n == poke + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el,
                     input logic dbz);
    launch(o, x, y);
    wait_done(-5);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
  endtask

  initial begin
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-5);
    check("multu_lat", 64'(n), 64'd33);
    check("multu_busy", 64'(bcnt), 64'd33);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("multu_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("hold_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run("mult_n3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5,
        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run("mult_n1xn1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0, 32'h1, 1'b0);
    run("div_n7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_7dn2", MD_DIV, 32'd7, 32'hFFFF_FFFE,
        32'h1, 32'hFFFF_FFFD, 1'b0);
    run("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'd2,
        32'h1, 32'h7FFF_FFFC, 1'b0);
    run("divu_z", MD_DIVU, 32'd100, 32'd0,
        32'h64, 32'hFFFF_FFFF, 1'b1);
    run("div_negz", MD_DIV, 32'hFFFF_FFF9, 32'd0,
        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000, 1'b0);

    // start + MTHI/MTLO while busy at cycle 5: both ignored
    launch(MD_MULTU, 32'd6, 32'd7);
    wait_done(5);
    check("ign_lat", 64'(n), 64'd33);
    check("ign_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("ign_no2nd", 64'(dcnt), 64'd0);

    // start in the done cycle is accepted
    launch(MD_DIVU, 32'd100, 32'd7);
    wait_done(-5);
    check("b2b_first", {hi, lo}, 64'h0000_0002_0000_000E);
    op = MD_MULT; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(-5);
    check("b2b_lat", 64'(n), 64'd33);
    check("b2b_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    // MTHI with an accepted start is dropped
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    launch(MD_MULTU, 32'd2, 32'd3);
    hi_we = 1'b0; lo_we = 1'b0;
    check("we_start_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(-5);
    check("we_start_res", {hi, lo}, 64'h0000_0000_0000_0006);

    // idle MTLO / MTHI
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, 64'h0000_0000_0000_1234);
    hi_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi", {hi, lo}, 64'h0000_5678_0000_1234);

    // async reset at iteration 10
    launch(MD_MULTU, 32'd3, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("rst_nodone", 64'(dcnt), 64'd0);
    check("rst_hold", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
